bundler_readout_ctrl: RTL and testbench

Control and readout stage placed directly downstream of the per-bit saturating bundler counter array.
- Gates upstream hypervector items into the array (drives the counters' valid), and counts items per bundle set.
- After the last item of a set, samples all counters and binarizes them into one output hypervector. Zero counters take their bit from a tie-break vector.
- Presents the result on a valid/ready output, then pulses clear to the counter array for the next set.

---
 rtl/bundler_readout_ctrl.sv | 93 +++++++++
 tb/tb_bundler_readout_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bundler_readout_ctrl.sv
// Gates items into the bundler counter array, then binarizes the counters into one hypervector per set.
// Result valid two cycles after the last-item handshake; output holds until taken, and intake stalls meanwhile.
module bundler_readout_ctrl #(
    parameter int HVDimension    = 512,
    parameter int CounterWidth   = 8,
    parameter int ItemCountWidth = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clr_i,
    input  logic                                in_valid_i,
    input  logic                                in_last_i,
    output logic                                in_ready_o,
    output logic                                bundle_valid_o,
    output logic                                bundle_clr_o,
    input  logic [HVDimension*CounterWidth-1:0] counters_i,
    input  logic [HVDimension-1:0]              tie_hv_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [HVDimension-1:0]              out_hv_o,
    output logic [ItemCountWidth-1:0]           out_count_o,
    output logic                                busy_o
);

    typedef enum logic [1:0] {ACCUM, SETTLE, OUT, CLEAR} state_e;

    state_e                    state_q, state_d;
    logic [ItemCountWidth-1:0] item_cnt_q;
    logic [HVDimension-1:0]    bin_hv;
    logic                      item_hs;

    assign in_ready_o     = (state_q == ACCUM);
    assign bundle_valid_o = in_valid_i & in_ready_o;
    assign bundle_clr_o   = (state_q == CLEAR);
    assign busy_o         = (state_q != ACCUM);
    assign item_hs        = bundle_valid_o;

    // Sign bit set means negative; otherwise any nonzero bit means positive.
    for (genvar i = 0; i < HVDimension; i++) begin : g_bin
        assign bin_hv[i] = counters_i[i*CounterWidth + CounterWidth - 1] ? 1'b0 :
                           (|counters_i[i*CounterWidth +: CounterWidth]) ? 1'b1 :
                           tie_hv_i[i];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (item_hs && in_last_i) state_d = SETTLE;
            SETTLE:  state_d = OUT;
            OUT:     if (out_ready_i) state_d = CLEAR;
            CLEAR:   state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (clr_i) state_d = CLEAR;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ACCUM;
            item_cnt_q  <= '0;
            out_valid_o <= 1'b0;
            out_hv_o    <= '0;
            out_count_o <= '0;
        end else begin
            state_q <= state_d;
            if (clr_i) begin
                // An aborted set drops its pending item and any unread result.
                item_cnt_q  <= '0;
                out_valid_o <= 1'b0;
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (item_hs && (item_cnt_q != '1))
                            item_cnt_q <= item_cnt_q + ItemCountWidth'(1);
                    end
                    SETTLE: begin
                        out_hv_o    <= bin_hv;
                        out_count_o <= item_cnt_q;
                        out_valid_o <= 1'b1;
                    end
                    OUT: begin
                        if (out_ready_i) out_valid_o <= 1'b0;
                    end
                    CLEAR: begin
                        item_cnt_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bundler_readout_ctrl.sv
// Bench for bundler_readout_ctrl driving a behavioural 4x4-bit saturating counter array.
module tb_bundler_readout_ctrl;

    localparam int HVD = 4;
    localparam int CW  = 4;
    localparam int ICW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              clr, in_valid, in_last, out_ready;
    logic [HVD-1:0]    item, tie_hv;
    logic              in_ready, bundle_valid, bundle_clr, out_valid, busy;
    logic [HVD-1:0]    out_hv;
    logic [ICW-1:0]    out_count;
    logic [HVD*CW-1:0] counters;
    logic signed [CW-1:0] cnt [HVD];

    int checks = 0;
    int errors = 0;

    logic [HVD-1:0] exp_hv_q  [$];
    logic [ICW-1:0] exp_cnt_q [$];

    bundler_readout_ctrl #(
        .HVDimension(HVD), .CounterWidth(CW), .ItemCountWidth(ICW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
        .bundle_valid_o(bundle_valid), .bundle_clr_o(bundle_clr),
        .counters_i(counters), .tie_hv_i(tie_hv),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_hv_o(out_hv), .out_count_o(out_count), .busy_o(busy)
    );

    // Counter array: +1 for a one bit, -1 for a zero bit, saturating at +7/-8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HVD; i++) cnt[i] <= '0;
        end else if (bundle_clr) begin
            for (int i = 0; i < HVD; i++) cnt[i] <= '0;
        end else if (bundle_valid) begin
            for (int i = 0; i < HVD; i++) begin
                if (item[i]) begin
                    if (cnt[i] != 4'sb0111) cnt[i] <= cnt[i] + 4'sd1;
                end else begin
                    if (cnt[i] != 4'sb1000) cnt[i] <= cnt[i] - 4'sd1;
                end
            end
        end
    end
    assign counters = {cnt[3], cnt[2], cnt[1], cnt[0]};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_hv_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got hv %b, expected no output", out_hv);
            end else begin
                check("out_hv", 32'(out_hv), 32'(exp_hv_q.pop_front()));
                check("out_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [HVD-1:0] bits, input logic last);
        int n = 0;
        item = bits;
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready_o got 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid_o got 0, expected 1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((!in_ready || out_valid) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready_o got 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no end, expected finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        item = '0; tie_hv = '0;

        #2;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_bundle_clr", 32'(bundle_clr), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_hv", 32'(out_hv), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_busy", 32'(busy), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Majority: +3,-1,-1,-1 and the output latency.
        exp_hv_q.push_back(4'b1000); exp_cnt_q.push_back(2'd3);
        send(4'b1100, 1'b0);
        send(4'b1010, 1'b0);
        send(4'b1001, 1'b1);
        @(negedge clk);
        check("lat_settle_valid", 32'(out_valid), 0);
        check("settle_busy", 32'(busy), 1);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 1);
        wait_idle();

        // Tie: +2,0,0,-2 with tie 0110.
        tie_hv = 4'b0110;
        exp_hv_q.push_back(4'b1110); exp_cnt_q.push_back(2'd2);
        send(4'b1100, 1'b0);
        send(4'b1010, 1'b1);
        wait_idle();

        // Same set with tie 0000, held under backpressure.
        tie_hv = 4'b0000;
        out_ready = 1'b0;
        exp_hv_q.push_back(4'b1000); exp_cnt_q.push_back(2'd2);
        send(4'b1100, 1'b0);
        send(4'b1010, 1'b1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_hv", 32'(out_hv), 32'h8);
            check("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("clr_pulse", 32'(bundle_clr), 1);
        check("clr_in_ready", 32'(in_ready), 0);
        check("clr_out_valid", 32'(out_valid), 0);
        check("clr_out_hv_hold", 32'(out_hv), 32'h8);
        @(negedge clk);
        check("post_clr_pulse", 32'(bundle_clr), 0);
        check("post_clr_in_ready", 32'(in_ready), 1);
        check("post_clr_counters", 32'(counters), 0);
        @(posedge clk);
        #1;

        // Single-item set.
        exp_hv_q.push_back(4'b0101); exp_cnt_q.push_back(2'd1);
        send(4'b0101, 1'b1);
        wait_idle();

        // Abort with clr_i coinciding with a last-item handshake.
        send(4'b1100, 1'b0);
        send(4'b1010, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; item = 4'b1111;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("abort_clr_pulse", 32'(bundle_clr), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 1);
        @(negedge clk);
        check("abort_in_ready_after", 32'(in_ready), 1);
        check("abort_counters", 32'(counters), 0);
        check("abort_no_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        exp_hv_q.push_back(4'b1111); exp_cnt_q.push_back(2'd1);
        send(4'b1111, 1'b1);
        wait_idle();

        // Item count saturates at 3 for a six-item set.
        exp_hv_q.push_back(4'b1111); exp_cnt_q.push_back(2'd3);
        for (int i = 0; i < 6; i++) send(4'b1111, i == 5);
        @(negedge clk);
        check("sat_counters", 32'(counters), 32'h6666);
        wait_idle();

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        send(4'b0011, 1'b1);
        wait_out();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_out_hv", 32'(out_hv), 0);
        check("arst_out_count", 32'(out_count), 0);
        check("arst_counters", 32'(counters), 0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_stays_idle", 32'(out_valid), 0);

        check("queue_empty", 32'(exp_hv_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
